// File: rtl/csa_shared_add_sched.sv
// rtl/csa_shared_add_sched.sv - two-requester round-robin scheduler over one shared 4-bit carry-select adder slice
// Contains the slice (csa_slice4) and the nibble-serial scheduler top (csa_shared_add_sched).

module csa_slice4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_s0;
  logic [4:0] w_s1;

  // Both carry hypotheses are computed up front; cin only drives the final select.
  assign w_s0 = {1'b0, i_a} + {1'b0, i_b};
  assign w_s1 = {1'b0, i_a} + {1'b0, i_b} + 5'd1;
  assign {o_cout, o_sum} = i_cin ? w_s1 : w_s0;
endmodule

module csa_shared_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_last;
  logic [CW+1:0]    w_sh;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_sum_merge;

  // Contention goes to whichever requester was not granted last.
  assign w_grant0 = (r_state == S_IDLE) && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = (r_state == S_IDLE) && req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept = w_grant0 || w_grant1;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_last = (r_cnt == CW'(NIB - 1));
  assign w_sh   = {r_cnt, 2'b00};
  assign w_a_sh = r_a >> w_sh;
  assign w_b_sh = r_b >> w_sh;

  csa_slice4 u_slice (
    .i_a    (w_a_sh[3:0]),
    .i_b    (w_b_sh[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  assign w_sum_merge = (rsp_sum & ~(WIDTH'(4'hF) << w_sh)) | (WIDTH'(w_slice_sum) << w_sh);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
    end else begin
      r_state   <= w_next;
      rsp_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant1 ? req1_a : req0_a;
            r_b          <= w_grant1 ? req1_b : req0_b;
            r_carry      <= w_grant1 ? req1_cin : req0_cin;
            r_cnt        <= '0;
            r_last_grant <= w_grant1;
            rsp_id       <= w_grant1;
          end
        end
        S_RUN: begin
          rsp_sum <= w_sum_merge;
          r_carry <= w_slice_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) rsp_cout <= w_slice_cout;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_shared_add_sched.sv
// tb/tb_csa_shared_add_sched.sv - scoreboard bench for csa_shared_add_sched
// Expected results are queued as stimulus is driven and compared as responses complete.

module tb_csa_shared_add_sched;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  always #5 clk = ~clk;

  csa_shared_add_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout)
  );

  typedef struct packed {
    logic         id;
    logic         cout;
    logic [W-1:0] sum;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c);
    logic [W:0] f;
    exp_t r;
    f = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    r.id = id;
    r.cout = f[W];
    r.sum = f[W-1:0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_sum), 32'hDEAD);
      end else begin
        e_mon = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e_mon.id));
        check("rsp_sum", 32'(rsp_sum), 32'(e_mon.sum));
        check("rsp_cout", 32'(rsp_cout), 32'(e_mon.cout));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic v);
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = c; req1_valid = v;
    end else begin
      req0_a = a; req0_b = b; req0_cin = c; req0_valid = v;
    end
  endtask

  task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input bit push);
    bit got;
    if (push) sb.push_back(mk(id, a, b, c));
    drive(id, a, b, c, 1'b1);
    got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
    end
    if (!got) check("accept_timeout", 0, 1);
    step;
    drive(id, a, b, c, 1'b0);
  endtask

  task automatic contend(input int n, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic c0, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic c1);
    int acc;
    logic exp_id;
    for (int k = 0; k < n; k++)
      sb.push_back((k % 2) ? mk(1'b1, a1, b1, c1) : mk(1'b0, a0, b0, c0));
    drive(1'b0, a0, b0, c0, 1'b1);
    drive(1'b1, a1, b1, c1, 1'b1);
    acc = 0;
    exp_id = 1'b0;
    for (int i = 0; i < 200 && acc < n; i++) begin
      @(negedge clk);
      check("both_ready", 32'(req0_ready & req1_ready), 0);
      if (req0_ready | req1_ready) begin
        check("grant_order", 32'(req1_ready), 32'(exp_id));
        exp_id = ~exp_id;
        acc++;
      end
    end
    if (acc < n) check("contend_timeout", acc, n);
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && (sb.size() != 0 || rsp_valid); i++) step;
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, '0, '0, 1'b0, 1'b0);

    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_sum", 32'(rsp_sum), 0);
    check("rst_rsp_cout", 32'(rsp_cout), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 0);
    step;
    rst_n = 1'b1;
    step;

    send(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) lat = i;
    end
    check("latency", lat, 5);
    step;
    drain;

    send(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1);
    drain;
    send(1'b0, 16'h7FFF, 16'h0000, 1'b1, 1);
    drain;

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      send(1'(i % 2), ra, rb, 1'($urandom_range(1, 0)), 1);
      drain;
    end

    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    contend(3, 16'h0101, 16'h0202, 1'b0, 16'hF00F, 16'h0FF1, 1'b1);
    drain;

    rsp_ready = 1'b0;
    send(1'b0, 16'hA5A5, 16'h5A5A, 1'b1, 1);
    sb.push_back(mk(1'b1, 16'h0102, 16'h0304, 1'b0));
    drive(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_sum", 32'(rsp_sum), 32'h0000);
      check("bp_cout", 32'(rsp_cout), 1);
      check("bp_id", 32'(rsp_id), 0);
      check("bp_no_ready", 32'({req1_ready, req0_ready}), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_xfer_no_ready", 32'(req1_ready), 0);
    @(negedge clk);
    check("bp_valid_drop", 32'(rsp_valid), 0);
    check("bp_next_accept", 32'(req1_ready), 1);
    step;
    req1_valid = 1'b0;
    drain;

    send(1'b0, 16'h1111, 16'h2222, 1'b0, 0);
    step;
    step;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_sum", 32'(rsp_sum), 0);
    check("mid_rst_cout", 32'(rsp_cout), 0);
    check("mid_rst_id", 32'(rsp_id), 0);
    check("mid_rst_ready", 32'({req1_ready, req0_ready}), 0);
    step;
    step;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("aborted_no_rsp", 32'(rsp_valid), 0);
    end
    step;
    contend(2, 16'h00FF, 16'h0001, 1'b0, 16'h8000, 16'h8000, 1'b1);
    drain;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
